// File: rtl/hps_image_bridge_pkg.sv
// hps_image_bridge_pkg
// Shared definitions for the HPS image bridge:
//   - default image geometry and pixel count
//   - command word opcodes and field positions
//   - command FSM state encoding
//   - status word bit positions and a status packing helper
package hps_image_bridge_pkg;

  localparam int IMG_W_DEF  = 160;
  localparam int IMG_H_DEF  = 120;
  localparam int IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;

  // Command word layout: [31:30] opcode, [22:8] pixel address, [7:0] pixel data
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_START  = 2'b10;
  localparam logic [1:0] OP_COMMIT = 2'b11;

  localparam int CMD_OP_LSB   = 30;
  localparam int CMD_ADDR_LSB = 8;
  localparam int CMD_ADDR_W   = 15;
  localparam int CMD_DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_WAIT_REQ = 2'd0,
    ST_EXEC     = 2'd1,
    ST_ACK      = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  // Status word layout
  localparam int STAT_VALID     = 0;
  localparam int STAT_LOADING   = 1;
  localparam int STAT_ERR       = 2;
  localparam int STAT_COUNT_LSB = 16;

  function automatic logic [31:0] pack_status(input logic valid, input logic loading,
                                              input logic err, input logic [15:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_VALID]                = valid;
    s[STAT_LOADING]              = loading;
    s[STAT_ERR]                  = err;
    s[STAT_COUNT_LSB +: 16]      = count;
    return s;
  endfunction

endpackage

// File: rtl/hps_image_bridge_if.sv
// hps_image_bridge_if
// Bundles the HPS command handshake and the copier read port.
//   hps_cmd    : command word (HPS -> bridge), stable while hps_req=1
//   hps_req    : request, asynchronous to the bridge clock
//   hps_ack    : acknowledge (bridge -> HPS)
//   hps_status : {count[15:0], 13'd0, err, loading, image_valid}
//   rom_addr   : pixel read address (copier -> bridge)
//   rom_data   : {24'd0, pixel}, two clocks after rom_addr
// master = HPS/copier side, slave = bridge.
interface hps_image_bridge_if #(
  parameter int ADDR_W = 15
);
  logic [31:0]       hps_cmd;
  logic              hps_req;
  logic              hps_ack;
  logic [31:0]       hps_status;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;

  modport master (
    output hps_cmd, hps_req, rom_addr,
    input  hps_ack, hps_status, rom_data
  );

  modport slave (
    input  hps_cmd, hps_req, rom_addr,
    output hps_ack, hps_status, rom_data
  );
endinterface

// File: rtl/hps_image_bridge_image_ram.sv
// hps_image_bridge_image_ram
// Simple dual-port image store: one write port, one registered read port.
// A read and write to the same address on the same edge returns the old data.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data (one clock after rd_addr)
module hps_image_bridge_image_ram #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_reg;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/hps_image_bridge.sv
// hps_image_bridge
// HPS-facing image source: HPS uploads an image through a command word and a
// 4-phase req/ack handshake; the framebuffer copier reads pixels back with a
// fixed two-clock latency.
//   clk_50MHz : system clock
//   vga_reset : asynchronous active-low reset
//   bus       : slave side of hps_image_bridge_if (command handshake, status,
//               pixel read port)
module hps_image_bridge
  import hps_image_bridge_pkg::*;
#(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_50MHz,
  input  logic                  vga_reset,
  hps_image_bridge_if.slave     bus
);

  localparam logic [31:0] PIXELS = 32'(IMG_W * IMG_H);

  // ---------------------------------------------------------------- req sync
  logic [SYNC_STAGES-1:0] req_sync_reg;
  logic                   req_s;

  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      req_sync_reg <= '0;
    end else begin
      req_sync_reg[0] <= bus.hps_req;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync_reg[i] <= req_sync_reg[i-1];
      end
    end
  end

  assign req_s = req_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------- command FSM
  state_t                  state_reg;
  logic [1:0]              cmd_op_reg;
  logic [CMD_ADDR_W-1:0]   cmd_addr_reg;
  logic [CMD_DATA_W-1:0]   cmd_data_reg;
  logic                    ack_reg;
  logic                    valid_reg;
  logic                    loading_reg;
  logic                    err_reg;
  logic [15:0]             count_reg;
  logic                    addr_ok;
  logic                    wr_en;

  assign addr_ok = 32'(cmd_addr_reg) < PIXELS;
  // RAM write lands on the same edge that leaves EXEC, alongside the status update.
  assign wr_en   = (state_reg == ST_EXEC) && (cmd_op_reg == OP_WRITE) && loading_reg && addr_ok;

  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      state_reg    <= ST_WAIT_REQ;
      cmd_op_reg   <= OP_NOP;
      cmd_addr_reg <= '0;
      cmd_data_reg <= '0;
      ack_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      loading_reg  <= 1'b0;
      err_reg      <= 1'b0;
      count_reg    <= '0;
    end else begin
      case (state_reg)
        ST_WAIT_REQ: begin
          if (req_s) begin
            // Only this edge samples hps_cmd; later changes are ignored.
            cmd_op_reg   <= bus.hps_cmd[CMD_OP_LSB +: 2];
            cmd_addr_reg <= bus.hps_cmd[CMD_ADDR_LSB +: CMD_ADDR_W];
            cmd_data_reg <= bus.hps_cmd[0 +: CMD_DATA_W];
            state_reg    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cmd_op_reg)
            OP_WRITE: begin
              if (loading_reg && addr_ok) begin
                if (count_reg != 16'hFFFF) begin
                  count_reg <= count_reg + 16'd1;
                end
              end else begin
                err_reg <= 1'b1;
              end
            end
            OP_START: begin
              loading_reg <= 1'b1;
              valid_reg   <= 1'b0;
              err_reg     <= 1'b0;
              count_reg   <= '0;
            end
            OP_COMMIT: begin
              if (loading_reg) begin
                loading_reg <= 1'b0;
                valid_reg   <= 1'b1;
              end else begin
                err_reg <= 1'b1;
              end
            end
            default: ;
          endcase
          state_reg <= ST_ACK;
        end
        ST_ACK: begin
          // Ack is a registered view of the state, so it rises one edge into ACK.
          ack_reg <= 1'b1;
          if (!req_s) begin
            state_reg <= ST_DROP;
          end
        end
        ST_DROP: begin
          ack_reg   <= 1'b0;
          state_reg <= ST_WAIT_REQ;
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= ST_WAIT_REQ;
        end
      endcase
    end
  end

  // Bits of the command word that carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^bus.hps_cmd[29:23];

  // ---------------------------------------------------------------- image store
  logic [7:0] ram_q;

  hps_image_bridge_image_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_image_ram (
    .clk     (clk_50MHz),
    .wr_en   (wr_en),
    .wr_addr (ADDR_W'(cmd_addr_reg)),
    .wr_data (cmd_data_reg),
    .rd_addr (bus.rom_addr),
    .rd_data (ram_q)
  );

  // ---------------------------------------------------------------- read port
  // Stage 1 runs alongside the RAM read and decides whether the pixel may be
  // shown; stage 2 is the output register.
  logic        rd_ok_reg;
  logic [31:0] rom_data_reg;

  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      rd_ok_reg    <= 1'b0;
      rom_data_reg <= '0;
    end else begin
      rd_ok_reg    <= valid_reg && (32'(bus.rom_addr) < PIXELS);
      rom_data_reg <= rd_ok_reg ? {24'd0, ram_q} : 32'd0;
    end
  end

  assign bus.hps_ack    = ack_reg;
  assign bus.hps_status = pack_status(valid_reg, loading_reg, err_reg, count_reg);
  assign bus.rom_data   = rom_data_reg;

endmodule

// File: tb/tb_hps_image_bridge.sv
module tb_hps_image_bridge;
  import hps_image_bridge_pkg::*;

  localparam int ADDR_W = 15;
  localparam int PIX    = 160 * 120;

  logic clk_50MHz = 1'b0;
  logic vga_reset = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  hps_image_bridge_if #(.ADDR_W(ADDR_W)) bus();

  hps_image_bridge #(
    .IMG_W       (160),
    .IMG_H       (120),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .vga_reset (vga_reset),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ------------------------------------------------------------ behavioural model
  bit         m_valid, m_loading, m_err;
  int         m_count;
  logic [7:0] m_mem [0:32767];
  bit         m_wr  [0:32767];

  function automatic logic [31:0] m_status();
    logic [15:0] c;
    c = 16'(m_count);
    return {c, 13'd0, m_err, m_loading, m_valid};
  endfunction

  task automatic model_cmd(input logic [31:0] c);
    int a;
    a = int'(c[22:8]);
    case (c[31:30])
      2'b01: begin
        if (m_loading && a < PIX) begin
          m_mem[a] = c[7:0];
          m_wr[a]  = 1'b1;
          if (m_count < 65535) m_count++;
        end else begin
          m_err = 1'b1;
        end
      end
      2'b10: begin
        m_loading = 1'b1; m_valid = 1'b0; m_err = 1'b0; m_count = 0;
      end
      2'b11: begin
        if (m_loading) begin m_loading = 1'b0; m_valid = 1'b1; end
        else m_err = 1'b1;
      end
      default: ;
    endcase
  endtask

  // {care, expected rom_data}; unwritten pixels of a valid image are unknown
  function automatic logic [32:0] rd_exp(input int a);
    if (m_valid && a < PIX) begin
      if (m_wr[a]) return {1'b1, 24'd0, m_mem[a]};
      return {1'b0, 32'd0};
    end
    return {1'b1, 32'd0};
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ compare process
  bit          chk_rd = 1'b0;
  bit          chk_st = 1'b0;
  logic [32:0] p1_val, p2_val;
  bit          p1_en = 1'b0, p2_en = 1'b0;
  int          p1_addr, p2_addr;

  always @(posedge clk_50MHz) begin
    p1_val  <= rd_exp(int'(bus.rom_addr));
    p1_addr <= int'(bus.rom_addr);
    p1_en   <= chk_rd && vga_reset;
    p2_val  <= p1_val;
    p2_addr <= p1_addr;
    p2_en   <= p1_en && vga_reset;
  end

  always @(negedge clk_50MHz) begin
    if (p2_en && p2_val[32] && vga_reset)
      chk32($sformatf("rom_data_addr_%0d", p2_addr), bus.rom_data, p2_val[31:0]);
    if (chk_st && vga_reset) begin
      chk32("status_idle", bus.hps_status, m_status());
      chk32("ack_idle", {31'd0, bus.hps_ack}, 32'd0);
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  function automatic logic [31:0] mk_wr(input int a, input int d);
    return {2'b01, 7'd0, 15'(a), 8'(d)};
  endfunction

  task automatic do_cmd(input logic [31:0] cmd);
    int lat, fall;
    chk_rd = 1'b0; chk_st = 1'b0;
    @(negedge clk_50MHz);
    bus.hps_cmd = cmd;
    bus.hps_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk_50MHz); @(negedge clk_50MHz);
      if (i == 3) bus.hps_cmd = $urandom;   // after the latch edge: must be ignored
      if (bus.hps_ack) lat = i;
    end
    chk32($sformatf("ack_rise_edges cmd=%h", cmd), 32'(lat), 32'd5);
    model_cmd(cmd);
    chk32($sformatf("status_in_ack cmd=%h", cmd), bus.hps_status, m_status());
    bus.hps_req = 1'b0;
    fall = 0;
    for (int i = 1; i <= 20 && fall == 0; i++) begin
      @(posedge clk_50MHz); @(negedge clk_50MHz);
      if (!bus.hps_ack) fall = i;
    end
    chk32($sformatf("ack_fall_edges cmd=%h", cmd), 32'(fall), 32'd4);
    chk_rd = 1'b1; chk_st = 1'b1;
  endtask

  task automatic cmd_lit(input logic [31:0] cmd, input logic [31:0] lit, input string name);
    do_cmd(cmd);
    chk32(name, bus.hps_status, lit);
  endtask

  task automatic rd1(input int a, input logic [31:0] lit, input string name);
    @(negedge clk_50MHz);
    bus.rom_addr = 15'(a);
    @(posedge clk_50MHz); @(posedge clk_50MHz); @(negedge clk_50MHz);
    chk32(name, bus.rom_data, lit);
  endtask

  task automatic rd_seq(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50MHz);
      bus.rom_addr = 15'(start + i);
    end
    repeat (3) @(negedge clk_50MHz);
  endtask

  task automatic rd_rand(input int n);
    int r, a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      a = $urandom_range(0, PIX-1);
      else if (r < 85) a = PIX - 1;
      else if (r < 90) a = PIX;
      else if (r < 95) a = 0;
      else             a = $urandom_range(PIX, 32767);
      @(negedge clk_50MHz);
      bus.rom_addr = 15'(a);
    end
    repeat (3) @(negedge clk_50MHz);
  endtask

  task automatic rand_cmds(input int n);
    int r;
    logic [31:0] c;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      c = {2'b01, 7'($urandom), 15'($urandom_range(0, PIX-1)), 8'($urandom)};
      else if (r < 80) c = {2'b01, 7'($urandom), 15'($urandom_range(PIX, 32767)), 8'($urandom)};
      else if (r < 90) c = {2'b00, 30'($urandom)};
      else if (r < 95) c = {2'b10, 30'($urandom)};
      else             c = {2'b11, 30'($urandom)};
      do_cmd(c);
    end
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin
    int lat;
    bus.hps_cmd  = '0;
    bus.hps_req  = 1'b0;
    bus.rom_addr = '0;
    m_valid = 1'b0; m_loading = 1'b0; m_err = 1'b0; m_count = 0;
    repeat (4) @(negedge clk_50MHz);
    vga_reset = 1'b1;
    @(negedge clk_50MHz);

    // Reset state
    chk32("reset_status", bus.hps_status, 32'h0000_0000);
    chk32("reset_ack", {31'd0, bus.hps_ack}, 32'd0);
    rd1(0, 32'h0, "reset_rom_data");

    // Error paths from idle, then START clears err
    cmd_lit({2'b11, 30'd0}, 32'h0000_0004, "commit_idle_err");
    cmd_lit(mk_wr(5, 8'h77), 32'h0000_0004, "write_no_load_err");
    cmd_lit({2'b10, 30'd0}, 32'h0000_0002, "start_clears_err");

    // Normal load
    cmd_lit(mk_wr(0, 8'hA5), 32'h0001_0002, "write0");
    cmd_lit(mk_wr(19199, 8'h3C), 32'h0002_0002, "write19199");
    cmd_lit({2'b11, 30'd0}, 32'h0002_0001, "commit");
    rd1(0, 32'h0000_00A5, "rd_addr0");
    rd1(19199, 32'h0000_003C, "rd_addr19199");
    rd1(19200, 32'h0, "rd_addr19200_oob");

    // Write while not loading leaves the RAM untouched
    cmd_lit(mk_wr(0, 8'hFF), 32'h0002_0005, "write_after_commit_err");
    rd1(0, 32'h0000_00A5, "rd_addr0_unchanged");

    // Reload blanking and out-of-range write while loading
    cmd_lit({2'b10, 30'd0}, 32'h0000_0002, "reload_start");
    rd1(0, 32'h0, "blank_addr0");
    rd1(19199, 32'h0, "blank_addr19199");
    rd_seq(0, 48);
    cmd_lit(mk_wr(19200, 8'h11), 32'h0000_0006, "write_oob_err");
    cmd_lit({2'b10, 30'd0}, 32'h0000_0002, "start_again");
    for (int i = 0; i < 64; i++) do_cmd(mk_wr(i, $urandom_range(0, 255)));
    cmd_lit({2'b11, 30'd0}, 32'h0040_0001, "commit_64");
    rd_seq(0, 80);

    // Randomised rounds
    for (int round = 0; round < 2; round++) begin
      do_cmd({2'b10, 30'd0});
      rand_cmds(40);
      do_cmd({2'b11, 30'd0});
      rd_rand(150);
    end

    // Reset while in ACK
    chk_rd = 1'b0; chk_st = 1'b0;
    @(negedge clk_50MHz);
    bus.hps_cmd = {2'b10, 30'd0};
    bus.hps_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk_50MHz); @(negedge clk_50MHz);
      if (bus.hps_ack) lat = i;
    end
    chk32("ack_before_reset_edges", 32'(lat), 32'd5);
    #3 vga_reset = 1'b0;
    #1;
    chk32("ack_async_drop", {31'd0, bus.hps_ack}, 32'd0);
    chk32("status_async_clear", bus.hps_status, 32'h0000_0000);
    bus.hps_req = 1'b0;
    m_valid = 1'b0; m_loading = 1'b0; m_err = 1'b0; m_count = 0;
    repeat (3) @(negedge clk_50MHz);
    vga_reset = 1'b1;
    repeat (2) @(negedge clk_50MHz);
    chk_rd = 1'b1; chk_st = 1'b1;
    rd1(0, 32'h0, "post_reset_blank");
    cmd_lit({2'b10, 30'd0}, 32'h0000_0002, "post_reset_start");
    cmd_lit(mk_wr(7, 8'h5A), 32'h0001_0002, "post_reset_write");
    cmd_lit({2'b11, 30'd0}, 32'h0001_0001, "post_reset_commit");
    rd1(7, 32'h0000_005A, "post_reset_rd7");
    rd_rand(40);

    chk_rd = 1'b0; chk_st = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hps_image_bridge.md
Name: hps_image_bridge

Overview:
- HPS-facing end of the image-source interface: serves the framebuffer copier's rom_addr requests with rom_data.
- Image contents are uploaded by HPS software through a PIO command word and a 4-phase req/ack handshake.
- Contains a 160x120 8-bit image store, a command FSM, and a fixed-latency read port.
- Sits between the HPS PIO bridge and the display top level.

Parameters:
- IMG_W, 160, source image width in pixels
- IMG_H, 120, source image height in pixels
- ADDR_W, 15, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- SYNC_STAGES, 2, synchronizer depth on hps_req

Ports:
- clk_50MHz  in  1  system clock
- vga_reset  in  1  asynchronous, active-low reset
- hps_cmd  in  32  command word; must be stable while hps_req=1
- hps_req  in  1  HPS request, asynchronous to clk_50MHz
- hps_ack  out  1  request acknowledge
- hps_status  out  32  [0] image_valid, [1] loading, [2] err (sticky), [15:3] zero, [31:16] pixel write count
- rom_addr  in  ADDR_W  pixel read address from the copier
- rom_data  out  32  {24'd0, pixel}

Behaviour:
- Reset (async, active-low): hps_ack=0, rom_data=0, image_valid=0, loading=0, err=0, count=0, FSM=WAIT_REQ. Image RAM contents are not cleared.
- hps_req passes through SYNC_STAGES flops; the FSM uses only the synchronized value req_s.
- Command decode, opcode = hps_cmd[31:30]:
  - 00 NOP: no state change.
  - 01 WRITE: address = [22:8], data = [7:0]. If loading=1 and address < IMG_W*IMG_H: write RAM, count+1 (saturates at 16'hFFFF). Otherwise no write and err set.
  - 10 START_LOAD: loading=1, image_valid=0, err=0, count=0.
  - 11 COMMIT: if loading=1 then loading=0 and image_valid=1; otherwise err set.
- Every command is acked, including erroneous ones.
- FSM states:
  - WAIT_REQ: when req_s=1, latch hps_cmd and go to EXEC.
  - EXEC: perform the command (one cycle) and go to ACK.
  - ACK: hps_ack=1; when req_s=0, go to DROP.
  - DROP: hps_ack=0 and go to WAIT_REQ.
- Handshake timing: hps_req sampled high at edge N gives hps_ack=1 after edge N+SYNC_STAGES+2.
- Handshake rules:
  - A new command is accepted only after the req low/ack low cycle completes.
  - A req pulse shorter than the sync window may be missed; HPS must hold req until it sees ack.
  - Command latch occurs at the WAIT_REQ to EXEC transition, so hps_cmd changes after that edge are ignored.
- Read port: rom_data is valid 2 clk_50MHz cycles after rom_addr (RAM registered read plus output register). Fully pipelined, one address per cycle.
  - rom_addr >= IMG_W*IMG_H returns 0.
  - image_valid=0 returns 0, so the display shows black during load.
- Simultaneous write and read to the same address: the read returns old data.
- Reset mid-load: loading and image_valid cleared; a partially written image is not shown until the next START_LOAD/COMMIT.
- Reset during ACK: ack drops immediately (async). HPS must re-issue the command.
- hps_status is registered and updates the cycle after EXEC.

Decomposition:
- Shared package: opcode constants (OP_NOP, OP_WRITE, OP_START, OP_COMMIT), FSM state encoding, status bit indices, IMG_PIXELS = IMG_W*IMG_H.
- Sub-module image_ram: simple dual-port RAM, 1 write port, 1 registered read port, 8-bit x 2^ADDR_W, old-data on read-during-write. Infers to block RAM.

Test Plan:
- Reset state: after reset, status=0, hps_ack=0; rom_addr=0 gives rom_data=0 after 2 cycles.
- Normal load: START_LOAD; WRITE addr 0 = 8'hA5; WRITE addr 19199 = 8'h3C; COMMIT. Then status[0]=1, status[1]=0, status[31:16]=2; rom_addr=0 gives 32'h000000A5 and rom_addr=19199 gives 32'h0000003C, each 2 cycles later.
- Error paths:
  - WRITE without START_LOAD: err=1, RAM unchanged.
  - WRITE addr 19200 while loading: err=1, count unchanged.
  - COMMIT while idle: err=1.
  - A following START_LOAD clears err.
- Handshake timing: req rising at edge N gives ack at N+4; ack holds while req=1; ack falls 2 cycles after req_s falls. hps_cmd altered after the latch edge has no effect.
- Reload blanking: START_LOAD after a valid image makes rom_data=0 for all addresses until COMMIT. Back-to-back rom_addr 0,1,2,... returns a matching pixel stream with constant 2-cycle latency.
- Reset during ACK state: ack drops asynchronously, image_valid=0; the next full handshake is accepted normally.
